// File: rtl/ctrl_pipe_scoreboard.sv
// ctrl_pipe_scoreboard: control/valid pipe behind ID with load-use and
// multicycle interlocks, operand forwarding selects and a stall counter.
module ctrl_pipe_scoreboard #(
   parameter int CTRL_W     = 16,
   parameter int NUM_STAGES = 3,
   parameter int LOAD_LAT   = 1,
   localparam int SEL_W     = ($clog2(NUM_STAGES) > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid_i,
   input  logic [CTRL_W-1:0]            id_ctrl_i,
   input  logic [4:0]                   id_rd_i,
   input  logic [4:0]                   id_rs1_i,
   input  logic [4:0]                   id_rs2_i,
   input  logic                         id_rd_we_i,
   input  logic                         id_rs1_use_i,
   input  logic                         id_rs2_use_i,
   input  logic                         id_load_i,
   input  logic                         id_mc_i,
   input  logic                         mc_done_i,
   input  logic                         flush_i,
   output logic                         id_ready_o,
   output logic [NUM_STAGES-1:0]        stage_valid_o,
   output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl_o,
   output logic [SEL_W-1:0]             fwd_a_o,
   output logic [SEL_W-1:0]             fwd_b_o,
   output logic [4:0]                   wb_rd_o,
   output logic                         wb_rd_we_o,
   output logic                         mc_busy_o,
   output logic [31:0]                  stall_cnt_o
);

   logic [NUM_STAGES-1:0] valid_q, valid_d;
   logic [NUM_STAGES-1:0] rd_we_q, rd_we_d;
   logic [NUM_STAGES-1:0] load_q, load_d;
   logic [NUM_STAGES-1:0] mc_q, mc_d;
   logic [CTRL_W-1:0]     ctrl_q [NUM_STAGES];
   logic [CTRL_W-1:0]     ctrl_d [NUM_STAGES];
   logic [4:0]            rd_q [NUM_STAGES];
   logic [4:0]            rd_d [NUM_STAGES];
   logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d;
   logic                  rs1_use_q, rs1_use_d, rs2_use_q, rs2_use_d;
   logic [31:0]           stall_cnt_q, stall_cnt_d;

   logic ex_hold;
   logic load_use;
   logic accept;

   assign ex_hold    = valid_q[0] & mc_q[0] & ~mc_done_i;
   assign id_ready_o = ~ex_hold & ~load_use;
   assign accept     = id_valid_i & id_ready_o & ~flush_i;
   assign mc_busy_o  = ex_hold;

   // Detect a load in the first LOAD_LAT stages whose result ID wants to read
   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         if (valid_q[k] && load_q[k] && rd_we_q[k] && (rd_q[k] != 5'd0) &&
             (((rd_q[k] == id_rs1_i) && id_rs1_use_i) ||
              ((rd_q[k] == id_rs2_i) && id_rs2_use_i))) begin
            load_use = 1'b1;
         end
      end
   end

   // Advance the pipe; a held multicycle op freezes EX and drains a bubble behind it
   always_comb begin
      valid_d   = '0;
      rd_we_d   = '0;
      load_d    = '0;
      mc_d      = '0;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rs1_use_d = rs1_use_q;
      rs2_use_d = rs2_use_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
         ctrl_d[k] = '0;
         rd_d[k]   = '0;
      end
      if (ex_hold) begin
         valid_d[0] = valid_q[0];
         rd_we_d[0] = rd_we_q[0];
         load_d[0]  = load_q[0];
         mc_d[0]    = mc_q[0];
         ctrl_d[0]  = ctrl_q[0];
         rd_d[0]    = rd_q[0];
      end else if (accept) begin
         valid_d[0] = 1'b1;
         rd_we_d[0] = id_rd_we_i;
         load_d[0]  = id_load_i;
         mc_d[0]    = id_mc_i;
         ctrl_d[0]  = id_ctrl_i;
         rd_d[0]    = id_rd_i;
         rs1_d      = id_rs1_i;
         rs2_d      = id_rs2_i;
         rs1_use_d  = id_rs1_use_i;
         rs2_use_d  = id_rs2_use_i;
      end else begin
         rs1_d     = '0;
         rs2_d     = '0;
         rs1_use_d = 1'b0;
         rs2_use_d = 1'b0;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
         if (!(ex_hold && (k == 1))) begin
            valid_d[k] = valid_q[k-1];
            rd_we_d[k] = rd_we_q[k-1];
            load_d[k]  = load_q[k-1];
            mc_d[k]    = mc_q[k-1];
            ctrl_d[k]  = ctrl_q[k-1];
            rd_d[k]    = rd_q[k-1];
         end
      end
   end

   // Count stalled cycles, sticking at the all-ones value
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (id_valid_i && !id_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Pick the youngest producer for each EX operand; scanning oldest-first lets the youngest win
   always_comb begin
      fwd_a_o = '0;
      fwd_b_o = '0;
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
         if (valid_q[0] && valid_q[k] && rd_we_q[k] && (rd_q[k] != 5'd0)) begin
            if (rs1_use_q && (rd_q[k] == rs1_q)) fwd_a_o = SEL_W'(k);
            if (rs2_use_q && (rd_q[k] == rs2_q)) fwd_b_o = SEL_W'(k);
         end
      end
   end

   // Flatten the per-stage control words and expose the WB write port
   always_comb begin
      stage_ctrl_o = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         stage_ctrl_o[k*CTRL_W +: CTRL_W] = ctrl_q[k];
      end
   end

   assign stage_valid_o = valid_q;
   assign wb_rd_o       = valid_q[NUM_STAGES-1] ? rd_q[NUM_STAGES-1] : 5'd0;
   assign wb_rd_we_o    = valid_q[NUM_STAGES-1] & rd_we_q[NUM_STAGES-1];
   assign stall_cnt_o   = stall_cnt_q;

   // State registers; reset empties the pipe and clears the stall count at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         rd_we_q     <= '0;
         load_q      <= '0;
         mc_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rs1_use_q   <= 1'b0;
         rs2_use_q   <= 1'b0;
         stall_cnt_q <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            ctrl_q[k] <= '0;
            rd_q[k]   <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         rd_we_q     <= rd_we_d;
         load_q      <= load_d;
         mc_q        <= mc_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rs1_use_q   <= rs1_use_d;
         rs2_use_q   <= rs2_use_d;
         stall_cnt_q <= stall_cnt_d;
         for (int k = 0; k < NUM_STAGES; k++) begin
            ctrl_q[k] <= ctrl_d[k];
            rd_q[k]   <= rd_d[k];
         end
      end
   end

endmodule

// File: tb/tb_ctrl_pipe_scoreboard.sv
// tb_ctrl_pipe_scoreboard: two configurations (3 stages/1 load bubble and
// 5 stages/2 load bubbles) driven together, checked against an instruction-level model.
module tb_ctrl_pipe_scoreboard;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        id_valid, id_rd_we, id_rs1_use, id_rs2_use, id_load, id_mc, mc_done, flush;
   logic [15:0] id_ctrl;
   logic [4:0]  id_rd, id_rs1, id_rs2;

   logic        a_ready, a_wbwe, a_busy, b_ready, b_wbwe, b_busy;
   logic [2:0]  a_sv;
   logic [4:0]  b_sv;
   logic [47:0] a_ctrl;
   logic [79:0] b_ctrl;
   logic [1:0]  a_fa, a_fb;
   logic [2:0]  b_fa, b_fb;
   logic [4:0]  a_wbrd, b_wbrd;
   logic [31:0] a_cnt, b_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit run_cmp  = 1'b0;

   ctrl_pipe_scoreboard #(.CTRL_W(16), .NUM_STAGES(3), .LOAD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
      .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_we_i(id_rd_we),
      .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_load_i(id_load),
      .id_mc_i(id_mc), .mc_done_i(mc_done), .flush_i(flush), .id_ready_o(a_ready),
      .stage_valid_o(a_sv), .stage_ctrl_o(a_ctrl), .fwd_a_o(a_fa), .fwd_b_o(a_fb),
      .wb_rd_o(a_wbrd), .wb_rd_we_o(a_wbwe), .mc_busy_o(a_busy), .stall_cnt_o(a_cnt));

   ctrl_pipe_scoreboard #(.CTRL_W(16), .NUM_STAGES(5), .LOAD_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
      .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_we_i(id_rd_we),
      .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_load_i(id_load),
      .id_mc_i(id_mc), .mc_done_i(mc_done), .flush_i(flush), .id_ready_o(b_ready),
      .stage_valid_o(b_sv), .stage_ctrl_o(b_ctrl), .fwd_a_o(b_fa), .fwd_b_o(b_fb),
      .wb_rd_o(b_wbrd), .wb_rd_we_o(b_wbwe), .mc_busy_o(b_busy), .stall_cnt_o(b_cnt));

   // ---------------- instruction-level reference model ----------------
   typedef struct packed {
      logic        v;
      logic [15:0] ctrl;
      logic [4:0]  rd, rs1, rs2;
      logic        we, ld, mc, u1, u2;
   } ent_t;

   ent_t        m [2][8];
   logic [31:0] cnt_m [2];

   function automatic int nst(int d);
      return (d == 0) ? 3 : 5;
   endfunction

   function automatic int lat(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic ent_t id_ent();
      ent_t e;
      e.v = 1'b1; e.ctrl = id_ctrl; e.rd = id_rd; e.rs1 = id_rs1; e.rs2 = id_rs2;
      e.we = id_rd_we; e.ld = id_load; e.mc = id_mc; e.u1 = id_rs1_use; e.u2 = id_rs2_use;
      return e;
   endfunction

   function automatic bit m_hold(int d);
      return m[d][0].v && m[d][0].mc && !mc_done;
   endfunction

   function automatic bit m_ready(int d);
      bit lu;
      lu = 1'b0;
      for (int k = 0; k < lat(d); k++) begin
         if (m[d][k].v && m[d][k].ld && m[d][k].we && m[d][k].rd != 5'd0 &&
             ((m[d][k].rd == id_rs1 && id_rs1_use) || (m[d][k].rd == id_rs2 && id_rs2_use)))
            lu = 1'b1;
      end
      return !m_hold(d) && !lu;
   endfunction

   function automatic int m_fwd(int d, bit second);
      logic [4:0] src;
      logic       use_it;
      if (!m[d][0].v) return 0;
      src    = second ? m[d][0].rs2 : m[d][0].rs1;
      use_it = second ? m[d][0].u2 : m[d][0].u1;
      for (int k = 1; k < nst(d); k++) begin
         if (m[d][k].v && m[d][k].we && m[d][k].rd != 5'd0 && use_it && m[d][k].rd == src)
            return k;
      end
      return 0;
   endfunction

   function automatic ent_t next_ent(int d, int k);
      if (k == 0) begin
         if (m_hold(d)) return m[d][0];
         if (id_valid && m_ready(d) && !flush) return id_ent();
         return '0;
      end
      if (k == 1 && m_hold(d)) return '0;
      return m[d][k-1];
   endfunction

   function automatic logic [7:0] exp_sv(int d);
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < nst(d); k++) r[k] = m[d][k].v;
      return r;
   endfunction

   function automatic logic [127:0] exp_ctrl(int d);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < nst(d); k++) r[k*16 +: 16] = m[d][k].ctrl;
      return r;
   endfunction

   // Model state advances on the same edge as the DUTs
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) m[d][k] <= '0;
            cnt_m[d] <= '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nst(d); k++) m[d][k] <= next_ent(d, k);
            if (id_valid && !m_ready(d) && cnt_m[d] != 32'hFFFF_FFFF) cnt_m[d] <= cnt_m[d] + 32'd1;
         end
      end
   end

   task automatic check_val(string nm, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every cycle out of reset, compare both DUTs with the model
   always @(negedge clk) begin
      if (run_cmp && rst === 1'b0) begin
         check_val("a.ready", 128'(a_ready), 128'(m_ready(0)));
         check_val("a.valid", 128'(a_sv), 128'(exp_sv(0)));
         check_val("a.ctrl", 128'(a_ctrl), exp_ctrl(0));
         check_val("a.fwd_a", 128'(a_fa), 128'(m_fwd(0, 1'b0)));
         check_val("a.fwd_b", 128'(a_fb), 128'(m_fwd(0, 1'b1)));
         check_val("a.wb_rd", 128'(a_wbrd), 128'(m[0][2].v ? m[0][2].rd : 5'd0));
         check_val("a.wb_we", 128'(a_wbwe), 128'(m[0][2].v & m[0][2].we));
         check_val("a.busy", 128'(a_busy), 128'(m_hold(0)));
         check_val("a.cnt", 128'(a_cnt), 128'(cnt_m[0]));
         check_val("b.ready", 128'(b_ready), 128'(m_ready(1)));
         check_val("b.valid", 128'(b_sv), 128'(exp_sv(1)));
         check_val("b.ctrl", 128'(b_ctrl), exp_ctrl(1));
         check_val("b.fwd_a", 128'(b_fa), 128'(m_fwd(1, 1'b0)));
         check_val("b.fwd_b", 128'(b_fb), 128'(m_fwd(1, 1'b1)));
         check_val("b.wb_rd", 128'(b_wbrd), 128'(m[1][4].v ? m[1][4].rd : 5'd0));
         check_val("b.wb_we", 128'(b_wbwe), 128'(m[1][4].v & m[1][4].we));
         check_val("b.busy", 128'(b_busy), 128'(m_hold(1)));
         check_val("b.cnt", 128'(b_cnt), 128'(cnt_m[1]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic we, input logic ld,
                         input logic mc, input logic [15:0] ctrl);
      id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs1_use = u1; id_rs2 = rs2; id_rs2_use = u2;
      id_rd_we = we; id_load = ld; id_mc = mc; id_ctrl = ctrl;
   endtask

   task automatic idle(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_a(string tag);
      check_val({tag, ".ready"}, 128'(a_ready), 128'(1));
      check_val({tag, ".valid"}, 128'(a_sv), 128'(0));
      check_val({tag, ".ctrl"}, 128'(a_ctrl), 128'(0));
      check_val({tag, ".fwd_a"}, 128'(a_fa), 128'(0));
      check_val({tag, ".fwd_b"}, 128'(a_fb), 128'(0));
      check_val({tag, ".wb_rd"}, 128'(a_wbrd), 128'(0));
      check_val({tag, ".wb_we"}, 128'(a_wbwe), 128'(0));
      check_val({tag, ".busy"}, 128'(a_busy), 128'(0));
      check_val({tag, ".cnt"}, 128'(a_cnt), 128'(0));
      check_val({tag, ".b_valid"}, 128'(b_sv), 128'(0));
      check_val({tag, ".b_cnt"}, 128'(b_cnt), 128'(0));
   endtask

   initial begin
      mc_done = 0; flush = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
      #3;
      check_reset_a("rst0");
      step(); step();
      rst = 1'b0;
      run_cmp = 1'b1;

      // back-to-back ALU forwarding
      set_id(1, 5, 1, 1, 2, 1, 1, 0, 0, 16'h0A01); step();
      set_id(1, 6, 5, 1, 0, 0, 1, 0, 0, 16'h0A02); step();
      #1 check_val("alu.fwd1", 128'(a_fa), 128'(1));
      set_id(1, 8, 5, 1, 0, 0, 1, 0, 0, 16'h0A03); step();
      #1 check_val("alu.fwd2", 128'(a_fa), 128'(2));
      check_val("alu.wb_rd", 128'(a_wbrd), 128'(5));
      check_val("alu.wb_we", 128'(a_wbwe), 128'(1));
      check_val("alu.ctrl2", 128'(a_ctrl[47:32]), 128'(16'h0A01));
      idle(6);

      // load-use: one bubble, then forward from stage 2
      set_id(1, 7, 1, 1, 0, 0, 1, 1, 0, 16'h0B01); step();
      set_id(1, 9, 0, 0, 7, 1, 1, 0, 0, 16'h0B02);
      #1 check_val("lu.stall", 128'(a_ready), 128'(0));
      step();
      #1 check_val("lu.bubble", 128'(a_sv), 128'(3'b010));
      check_val("lu.ready", 128'(a_ready), 128'(1));
      step();
      #1 check_val("lu.fwd_b", 128'(a_fb), 128'(2));
      check_val("lu.cnt", 128'(a_cnt), 128'(1));
      idle(6);

      // multicycle hold of 4 cycles, with a flush attempted during the hold
      set_id(1, 10, 1, 1, 0, 0, 1, 0, 1, 16'h0C01); step();
      set_id(1, 11, 2, 1, 0, 0, 1, 0, 0, 16'h0C02);
      for (int i = 0; i < 4; i++) begin
         flush = (i == 2);
         #1;
         check_val("mc.busy", 128'(a_busy), 128'(1));
         check_val("mc.ready", 128'(a_ready), 128'(0));
         check_val("mc.valid", 128'(a_sv), 128'(3'b001));
         check_val("mc.ctrl0", 128'(a_ctrl[15:0]), 128'(16'h0C01));
         step();
      end
      flush = 0; mc_done = 1;
      #1 check_val("mc.done_busy", 128'(a_busy), 128'(0));
      check_val("mc.done_ready", 128'(a_ready), 128'(1));
      step();
      mc_done = 0;
      #1 check_val("mc.after", 128'(a_sv), 128'(3'b011));
      check_val("mc.ctrl1", 128'(a_ctrl[31:16]), 128'(16'h0C01));
      check_val("mc.ctrl0n", 128'(a_ctrl[15:0]), 128'(16'h0C02));
      check_val("mc.cnt", 128'(a_cnt), 128'(5));
      idle(6);

      // flush with no hazard squashes the ID instruction
      set_id(1, 12, 1, 1, 0, 0, 1, 0, 0, 16'h0E01); flush = 1;
      #1 check_val("fl.ready", 128'(a_ready), 128'(1));
      step();
      flush = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
      #1 check_val("fl.valid", 128'(a_sv), 128'(0));
      idle(6);

      // x0 load never stalls or forwards
      set_id(1, 0, 1, 1, 0, 0, 1, 1, 0, 16'h0F01); step();
      set_id(1, 13, 0, 1, 0, 1, 1, 0, 0, 16'h0F02);
      #1 check_val("x0.ready", 128'(a_ready), 128'(1));
      step();
      #1 check_val("x0.fwd_a", 128'(a_fa), 128'(0));
      check_val("x0.fwd_b", 128'(a_fb), 128'(0));
      check_val("x0.valid", 128'(a_sv), 128'(3'b011));
      check_val("x0.cnt", 128'(a_cnt), 128'(5));
      idle(6);

      // reset pulsed mid-multicycle without a clock edge
      set_id(1, 14, 1, 1, 0, 0, 1, 0, 1, 16'h0D00); step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
      #1 check_val("rmc.busy", 128'(a_busy), 128'(1));
      step();
      rst = 1'b1;
      #1 check_reset_a("rmc");
      step();
      rst = 1'b0;
      set_id(1, 15, 1, 1, 0, 0, 1, 0, 0, 16'h0D01); step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
      #1 check_val("rmc.valid", 128'(a_sv), 128'(3'b001));
      check_val("rmc.ctrl0", 128'(a_ctrl[15:0]), 128'(16'h0D01));
      check_val("rmc.busy2", 128'(a_busy), 128'(0));
      idle(6);

      // deeper pipe: load-use needs two bubbles
      set_id(1, 7, 1, 1, 0, 0, 1, 1, 0, 16'h1001); step();
      set_id(1, 9, 0, 0, 7, 1, 1, 0, 0, 16'h1002);
      #1 check_val("b.lu.s1a", 128'(a_ready), 128'(0));
      check_val("b.lu.s1b", 128'(b_ready), 128'(0));
      step();
      #1 check_val("b.lu.s2a", 128'(a_ready), 128'(1));
      check_val("b.lu.s2b", 128'(b_ready), 128'(0));
      step();
      #1 check_val("b.lu.s3b", 128'(b_ready), 128'(1));
      step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
      #1 check_val("b.lu.cnt", 128'(b_cnt), 128'(2));
      check_val("b.lu.fwd_b", 128'(b_fb), 128'(3));
      idle(6);

      // randomized traffic over a small register set to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 16'($urandom));
         mc_done = ($urandom_range(0, 2) == 0);
         flush   = ($urandom_range(0, 9) == 0);
         step();
      end
      mc_done = 1; flush = 0;
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_scoreboard.md
CTRL_PIPE_SCOREBOARD -- requirements
Module: ctrl_pipe_scoreboard

Interface
REQ-001 Parameter CTRL_W, default 16: width of the opaque per-instruction control word carried down the pipe.
REQ-002 Parameter NUM_STAGES, default 3: number of post-ID stages; stage 0 = EX, stage NUM_STAGES-1 = WB; legal range 2..8.
REQ-003 Parameter LOAD_LAT, default 1: load-use bubbles required; legal range 1..NUM_STAGES-1.
REQ-004 Derived SEL_W = max(1, clog2(NUM_STAGES)).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 id_valid_i  in  1  ID holds an instruction.
REQ-008 id_ctrl_i  in  CTRL_W  decoded control word.
REQ-009 id_rd_i / id_rs1_i / id_rs2_i  in  5 each  register addresses.
REQ-010 id_rd_we_i, id_rs1_use_i, id_rs2_use_i, id_load_i, id_mc_i  in  1 each  writes rd / reads rs1 / reads rs2 / is load / is multicycle (mul/div).
REQ-011 mc_done_i  in  1  multicycle unit result ready this cycle.
REQ-012 flush_i  in  1  squash the instruction currently in ID.
REQ-013 id_ready_o  out  1  ID instruction accepted at next edge; 0 = stall PC and IF/ID.
REQ-014 stage_valid_o  out  NUM_STAGES  per-stage valid bit.
REQ-015 stage_ctrl_o  out  NUM_STAGES*CTRL_W  flat control words, stage k at [k*CTRL_W +: CTRL_W].
REQ-016 fwd_a_o / fwd_b_o  out  SEL_W each  EX operand source: 0 = register file, k = stage k result.
REQ-017 wb_rd_o (5), wb_rd_we_o (1)  out  rd and write enable of the WB stage, gated by its valid bit.
REQ-018 mc_busy_o  out  1  EX holds a valid multicycle op not yet done.
REQ-019 stall_cnt_o  out  32  saturating count of stalled cycles.

Function
REQ-020 Each stage entry SHALL hold: valid, ctrl, rd, rd_we, load, mc; stage 0 SHALL also hold rs1, rs2, rs1_use, rs2_use.
REQ-021 ex_hold = stage0.valid & stage0.mc & ~mc_done_i; mc_busy_o SHALL equal ex_hold.
REQ-022 load_use = 1 iff, for some k < LOAD_LAT, stage k is valid with load & rd_we & rd != 0, and rd matches id_rs1_i with id_rs1_use_i, or id_rs2_i with id_rs2_use_i.
REQ-023 id_ready_o SHALL be combinational: ~ex_hold & ~load_use.
REQ-024 Accept = id_valid_i & id_ready_o & ~flush_i.
REQ-025 Not ex_hold: stage 0 SHALL load the ID entry if Accept, else a bubble (valid=0, all fields 0).
REQ-026 Not ex_hold: stage k SHALL load stage k-1 for k >= 1.
REQ-027 ex_hold: stage 0 SHALL keep its contents, stage 1 SHALL load a bubble, and stages >= 2 SHALL advance normally (drain).
REQ-028 flush_i with id_ready_o=1 SHALL produce a bubble in stage 0.
REQ-029 flush_i with id_ready_o=0 SHALL have no effect here; the upstream IF/ID register owns the squash.
REQ-030 fwd_a_o SHALL be the smallest k in 1..NUM_STAGES-1 where stage k is valid & rd_we & rd != 0 & rd == stage0.rs1 & stage0.rs1_use; else 0. fwd_b_o is identical using rs2.
REQ-031 fwd_a_o / fwd_b_o SHALL be 0 whenever stage0.valid=0.
REQ-032 Register x0 SHALL never cause a hazard or a forward.
REQ-033 stall_cnt_o SHALL increment by 1 in each cycle with id_valid_i & ~id_ready_o, and hold at 32'hFFFF_FFFF once reached.
REQ-034 Latency: an accepted instruction SHALL appear in stage k exactly k+1 cycles after acceptance, plus any ex_hold cycles incurred while it is in stage 0.

Reset
REQ-035 rst=1 SHALL immediately clear every stage entry and stall_cnt_o to 0, independent of clk.
REQ-036 During reset: stage_valid_o=0, stage_ctrl_o=0, fwd_*=0, wb_rd_o=0, wb_rd_we_o=0, mc_busy_o=0, id_ready_o=1.
REQ-037 Assertion of rst mid-multicycle SHALL abandon the op; after release the first accepted instruction SHALL enter stage 0 normally.

Verification
REQ-038 Back-to-back ALU with defaults: add x5 then use x5 as rs1 -> second instruction in EX sees fwd_a_o=1; third instruction using x5 in EX sees fwd_a_o=2.
REQ-039 Load x7 then consumer using x7 as rs2 -> id_ready_o=0 for exactly 1 cycle, stage_valid_o=3'b010 in the bubble cycle, then fwd_b_o=2, stall_cnt_o=1.
REQ-040 div accepted, mc_done_i asserted 4 cycles later -> mc_busy_o=1 for 4 cycles, id_ready_o=0 for 4 cycles, stage 1 valid=0 throughout, and the div in stage 1 on the cycle after mc_done_i.
REQ-041 flush_i=1 with id_valid_i=1 and no hazard -> stage0 valid=0 next cycle; flush_i during a div hold -> stage contents unchanged.
REQ-042 rd=x0 load followed by consumer of x0 -> no stall, fwd_*=0.
REQ-043 rst pulsed mid-div (no clk edge) -> all outputs at reset values immediately; NUM_STAGES=5, LOAD_LAT=2 regression -> load-use stalls exactly 2 cycles.
